// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Seven-segment pattern table and shared segment constants.
//            Patterns are active-low, bit 0 = a ... bit 6 = g.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Digit glyphs 0..F, active-low segments g..a
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Every segment and the decimal point dark
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Segments a..g dark; the decimal point is handled separately
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/hex_seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : hex_seg_decode
// Brief    : Combinational nibble + decimal point to active-low 8-bit
//            segment pattern ({dp, g..a}).
// Revision : 1.0 - initial release
// ============================================================================
module hex_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // dp input is 1 = lit, so it is inverted onto the active-low dp segment
  always_comb begin
    seg = {~dp, SEG_TABLE[nibble]};
  end

endmodule : hex_seg_decode
`default_nettype wire

// File: rtl/hex_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : hex_seg_scan
// Brief    : Multiplexed hex display scanner with frame-synchronous
//            double-buffered load, leading-zero blanking and digit flashing.
//            All outputs are registered and active-low.
// Revision : 1.0 - initial release
// ============================================================================
module hex_seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 17,
  parameter int FLASH_DIV = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les,
  input  logic                  load,
  input  logic                  flash_en,
  input  logic                  lzb,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DIGITS - 1);

  logic [SCAN_DIV-1:0]  r_scan_cnt;
  logic [FLASH_DIV-1:0] r_flash_cnt;
  logic                 r_phase;
  logic [IDX_W-1:0]     r_idx;

  logic [4*DIGITS-1:0]  r_sh_hex,  r_act_hex;
  logic [DIGITS-1:0]    r_sh_pt,   r_act_pt;
  logic [DIGITS-1:0]    r_sh_le,   r_act_le;
  logic                 r_pending;

  logic [DIGITS-1:0]    r_an;
  logic [7:0]           r_seg;
  logic                 r_frame_done;

  logic                 w_tick;
  logic                 w_boundary;
  logic [IDX_W-1:0]     w_idx_next;
  logic                 w_phase_next;
  logic [4*DIGITS-1:0]  w_act_hex_next;
  logic [DIGITS-1:0]    w_act_pt_next;
  logic [DIGITS-1:0]    w_act_le_next;
  logic [3:0]           w_nib;
  logic                 w_pt;
  logic                 w_le;
  logic                 w_run_zero;
  logic                 w_blank;
  logic [7:0]           w_dec_seg;
  logic [7:0]           w_seg_next;

  assign w_tick       = &r_scan_cnt;
  assign w_boundary   = w_tick && (r_idx == C_LAST_IDX);
  assign w_phase_next = r_phase ^ (&r_flash_cnt);

  // Next digit slot: step on each scan tick, wrapping after the last digit
  always_comb begin
    w_idx_next = r_idx;
    if (w_tick) begin
      w_idx_next = (r_idx == C_LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Active register contents after this edge; a load on the boundary bypasses the shadow
  always_comb begin
    w_act_hex_next = r_act_hex;
    w_act_pt_next  = r_act_pt;
    w_act_le_next  = r_act_le;
    if (w_boundary) begin
      if (load) begin
        w_act_hex_next = hexs;
        w_act_pt_next  = points;
        w_act_le_next  = les;
      end else if (r_pending) begin
        w_act_hex_next = r_sh_hex;
        w_act_pt_next  = r_sh_pt;
        w_act_le_next  = r_sh_le;
      end
    end
  end

  // Select the upcoming digit and decide whether it is a leading zero
  always_comb begin
    w_nib      = 4'h0;
    w_pt       = 1'b0;
    w_le       = 1'b0;
    w_blank    = 1'b0;
    w_run_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_run_zero = w_run_zero & (w_act_hex_next[i*4 +: 4] == 4'h0);
      if (w_idx_next == IDX_W'(i)) begin
        w_nib   = w_act_hex_next[i*4 +: 4];
        w_pt    = w_act_pt_next[i];
        w_le    = w_act_le_next[i];
        w_blank = w_run_zero && (i != 0);
      end
    end
  end

  hex_seg_decode u_decode (
    .nibble (w_nib),
    .dp     (w_pt),
    .seg    (w_dec_seg)
  );

  // Flashing wins over blanking; blanking keeps the decimal point
  always_comb begin
    w_seg_next = w_dec_seg;
    if (flash_en && w_phase_next && w_le) begin
      w_seg_next = SEG_OFF;
    end else if (lzb && w_blank) begin
      w_seg_next = {~w_pt, SEG_BLANK};
    end
  end

  // Free-running scan and flash timebases plus the current digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_flash_cnt <= '0;
      r_phase     <= 1'b0;
      r_idx       <= '0;
    end else begin
      r_scan_cnt  <= r_scan_cnt + SCAN_DIV'(1);
      r_flash_cnt <= r_flash_cnt + FLASH_DIV'(1);
      r_phase     <= w_phase_next;
      r_idx       <= w_idx_next;
    end
  end

  // Shadow/active double buffer: updates become visible only at a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_hex  <= '0;
      r_sh_pt   <= '0;
      r_sh_le   <= '0;
      r_act_hex <= '0;
      r_act_pt  <= '0;
      r_act_le  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_act_hex <= w_act_hex_next;
      r_act_pt  <= w_act_pt_next;
      r_act_le  <= w_act_le_next;
      if (w_boundary) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_sh_hex  <= hexs;
        r_sh_pt   <= points;
        r_sh_le   <= les;
        r_pending <= 1'b1;
      end
    end
  end

  // Registered outputs; the cycle after a tick is a dead cycle on the anodes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= '1;
      r_seg        <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_tick ? '1 : ~(DIGITS'(1) << r_idx);
      r_seg        <= w_seg_next;
      r_frame_done <= w_boundary;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

endmodule : hex_seg_scan
`default_nettype wire
